// File: rtl/toggle_period_decoder.sv
// toggle_period_decoder
// Recovers the programmed delay of a rate divider from the spacing between
// edges of its toggling enable. Reports spacing-1, flags a stable rate via
// locked, and flags a stalled input via timeout.
// Optional build macro: SYNC_INPUT_EN adds a two-flop synchronizer on
// toggle_in, for a divider running on an unrelated clock.
module toggle_period_decoder #(
  parameter int WIDTH        = 27,
  parameter int LOCK_MATCHES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             toggle_in,
  input  logic             clear,
  output logic [WIDTH-1:0] delay_out,
  output logic             delay_valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic {
    ST_WAIT    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_MATCHES);

  state_t           state_r;
  logic             prev_r;
  logic [WIDTH-1:0] cnt_r;
  logic [3:0]       match_cnt_r;
  logic [WIDTH-1:0] delay_out_r;
  logic             delay_valid_r;
  logic             locked_r;
  logic             timeout_r;

  logic             tin_s;
  logic             edge_s;
  logic [WIDTH-1:0] meas_s;
  logic [3:0]       next_match_s;
  logic             next_locked_s;

`ifdef SYNC_INPUT_EN
  logic sync_q1_r;
  logic sync_q2_r;

  // Two-flop synchronizer for an asynchronous divider enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1_r <= 1'b0;
      sync_q2_r <= 1'b0;
    end else begin
      sync_q1_r <= toggle_in;
      sync_q2_r <= sync_q1_r;
    end
  end

  assign tin_s = sync_q2_r;
`else
  assign tin_s = toggle_in;
`endif

  assign edge_s = tin_s ^ prev_r;

  // Next match count and lock decision for a measurement taken this cycle
  always_comb begin
    meas_s       = cnt_r - CNT_ONE;
    next_match_s = 4'd1;
    if (match_cnt_r == 4'd0) begin
      // first measurement since WAIT: nothing valid to compare against
      next_match_s = 4'd1;
    end else if (meas_s == delay_out_r) begin
      if (match_cnt_r >= LOCK_N) begin
        next_match_s = LOCK_N;
      end else begin
        next_match_s = match_cnt_r + 4'd1;
      end
    end else begin
      next_match_s = 4'd1;
    end
    next_locked_s = (next_match_s >= LOCK_N);
  end

  // Edge history: follows the input every cycle, even during clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= tin_s;
    end
  end

  // Edge spacing counter, restarts at 1 on an edge and saturates at all-ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (edge_s) begin
      cnt_r <= CNT_ONE;
    end else if (cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Measurement FSM with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_WAIT;
      match_cnt_r   <= 4'd0;
      delay_out_r   <= '0;
      delay_valid_r <= 1'b0;
      locked_r      <= 1'b0;
      timeout_r     <= 1'b0;
    end else if (clear) begin
      // clear also swallows any coincident edge
      state_r       <= ST_WAIT;
      match_cnt_r   <= 4'd0;
      delay_out_r   <= '0;
      delay_valid_r <= 1'b0;
      locked_r      <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      delay_valid_r <= 1'b0;
      case (state_r)
        ST_WAIT: begin
          if (edge_s) begin
            state_r   <= ST_MEASURE;
            timeout_r <= 1'b0;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_MEASURE: begin
          if (edge_s) begin
            delay_out_r   <= meas_s;
            delay_valid_r <= 1'b1;
            match_cnt_r   <= next_match_s;
            locked_r      <= next_locked_s;
          end else if (cnt_r == CNT_MAX) begin
            // input stalled: drop lock, keep the last delay visible
            timeout_r   <= 1'b1;
            locked_r    <= 1'b0;
            match_cnt_r <= 4'd0;
            state_r     <= ST_WAIT;
          end else begin
            state_r <= ST_MEASURE;
          end
        end
        default: begin
          state_r     <= ST_WAIT;
          match_cnt_r <= 4'd0;
          locked_r    <= 1'b0;
        end
      endcase
    end
  end

  assign delay_out   = delay_out_r;
  assign delay_valid = delay_valid_r;
  assign locked      = locked_r;
  assign timeout     = timeout_r;

endmodule

// File: tb/tb_toggle_period_decoder.sv
// Scoreboard bench for toggle_period_decoder (WIDTH=4, LOCK_MATCHES=2).
// Stimulus pushes the expected (delay, locked) pair for every measuring
// edge; a negedge monitor pops one entry per delay_valid pulse.
module tb_toggle_period_decoder;

  localparam int W = 4;

  logic         clk;
  logic         reset_n;
  logic         toggle_in;
  logic         clear;
  logic [W-1:0] delay_out;
  logic         delay_valid;
  logic         locked;
  logic         timeout;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  exp_t exp_q[$];
  int   vectors;
  int   miscompares;

  toggle_period_decoder #(.WIDTH(W), .LOCK_MATCHES(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .toggle_in   (toggle_in),
    .clear       (clear),
    .delay_out   (delay_out),
    .delay_valid (delay_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Wait n clocks then flip toggle_in: consecutive calls give edge spacing n
  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1 toggle_in = ~toggle_in;
  endtask

  task automatic gap_exp(input int n, input int d, input logic l);
    exp_t e;
    e.d = W'(d);
    e.l = l;
    exp_q.push_back(e);
    gap(n);
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("clear_delay", int'(delay_out), 0);
    check("clear_locked", int'(locked), 0);
    check("clear_timeout", int'(timeout), 0);
  endtask

  // Monitor: every delay_valid pulse must match the oldest expectation
  always @(negedge clk) begin
    if (reset_n && delay_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid actual=1 required=0 delay_out=%0d", delay_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("valid_delay", int'(delay_out), int'(e.d));
        check("valid_locked", int'(locked), int'(e.l));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    toggle_in   = 1'b0;
    clear       = 1'b0;
    #22;
    check("rst_delay", int'(delay_out), 0);
    check("rst_valid", int'(delay_valid), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_timeout", int'(timeout), 0);
    reset_n = 1'b1;

    // Spacing 5 (D=4): lock on the second equal measurement
    gap(3);
    gap_exp(5, 4, 1'b0);
    gap_exp(5, 4, 1'b1);
    gap_exp(5, 4, 1'b1);

    // Toggle every cycle from a fresh start
    do_clear();
    gap(2);
    gap_exp(1, 0, 1'b0);
    gap_exp(1, 0, 1'b1);
    gap_exp(1, 0, 1'b1);

    // Rate change 5 -> 8 drops lock, then relocks
    do_clear();
    gap(3);
    gap_exp(5, 4, 1'b0);
    gap_exp(5, 4, 1'b1);
    gap_exp(8, 7, 1'b0);
    gap_exp(8, 7, 1'b1);

    // Stop toggling: timeout exactly 15 cycles after the last edge
    repeat (15) @(posedge clk);
    #1 check("timeout_early", int'(timeout), 0);
    @(posedge clk);
    #1 check("timeout_set", int'(timeout), 1);
    check("timeout_locked", int'(locked), 0);
    check("timeout_hold_delay", int'(delay_out), 7);
    // Restart edge clears timeout without a measurement
    gap(3);
    @(posedge clk);
    #1 check("timeout_cleared", int'(timeout), 0);
    gap_exp(5, 5, 1'b0);  // one clock already consumed: spacing 6

    // Async reset in the middle of a spacing-9 measurement
    gap_exp(9, 8, 1'b0);
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("arst_delay", int'(delay_out), 0);
    check("arst_valid", int'(delay_valid), 0);
    check("arst_locked", int'(locked), 0);
    check("arst_timeout", int'(timeout), 0);
    toggle_in = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    gap(3);
    gap_exp(9, 8, 1'b0);
    gap_exp(9, 8, 1'b1);

    // clear coincident with an edge while locked: edge discarded
    repeat (4) @(posedge clk);
    #1 toggle_in = ~toggle_in;
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    check("clredge_delay", int'(delay_out), 0);
    check("clredge_locked", int'(locked), 0);
    check("clredge_valid", int'(delay_valid), 0);
    gap(2);
    gap_exp(3, 2, 1'b0);
    gap_exp(3, 2, 1'b1);

    repeat (4) @(posedge clk);
    #1 check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
